// File: rtl/systolic_mm_engine.sv
// -----------------------------------------------------------------------------
// systolic_mm_engine
//   Output-stationary N x N systolic matrix multiplier: C = A x B or C += A x B.
//   Operands are streamed in row-major order as (A[r][c], B[r][c]) pairs and
//   buffered. On start, row r of A enters the left edge delayed by r cycles and
//   column c of B enters the top edge delayed by c cycles. A moves right and B
//   moves down one register per hop. Each PE accumulates its own C element.
//   Results are read out in row-major order.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
//   both high. The producer holds its data stable while valid && !ready.
//   Load side: load_valid/load_ready. Readout side: out_valid/out_ready.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   load_valid/load_ready operand pair handshake, A_i/B_i carry element k
//   start                 begins compute, honoured only in LOADED
//   signed_mode           sampled at start: 1 = two's-complement operands
//   acc_mode              sampled at start: 1 = add to retained C
//   busy                  high in COMPUTE and OUTPUT
//   done                  one-cycle pulse on the last COMPUTE cycle
//   out_valid/out_ready   result handshake, result = C[idx], out_last on idx N*N-1
// -----------------------------------------------------------------------------
module systolic_mm_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic                  acc_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  out_last
);

  localparam int NN        = N * N;
  localparam int CW        = $clog2(NN + 3*N);
  localparam int LAST_COMP = 3*N - 2;
  localparam int PW        = 2*DATA_WIDTH + 2;
  localparam int XW        = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_LOADED  = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;          // load index, compute cycle, readout index
  logic                  sgn_q, sgn_d;
  logic                  acc_q, acc_d;
  logic                  load_ready_q, load_ready_d;
  logic [DATA_WIDTH-1:0] a_buf_q [NN];
  logic [DATA_WIDTH-1:0] a_buf_d [NN];
  logic [DATA_WIDTH-1:0] b_buf_q [NN];
  logic [DATA_WIDTH-1:0] b_buf_d [NN];
  logic [DATA_WIDTH-1:0] a_pipe_q [N][N];
  logic [DATA_WIDTH-1:0] a_pipe_d [N][N];
  logic [DATA_WIDTH-1:0] b_pipe_q [N][N];
  logic [DATA_WIDTH-1:0] b_pipe_d [N][N];
  logic [ACC_WIDTH-1:0]  c_q [N][N];
  logic [ACC_WIDTH-1:0]  c_d [N][N];

  // PE datapath wires
  logic [DATA_WIDTH-1:0] inj_a [N];
  logic [DATA_WIDTH-1:0] inj_b [N];
  logic [DATA_WIDTH-1:0] a_in  [N][N];
  logic [DATA_WIDTH-1:0] b_in  [N][N];
  logic [ACC_WIDTH-1:0]  prod  [N][N];

  // Operands are widened by one bit (sign or zero) so a single signed
  // multiplier serves both modes; the low ACC_WIDTH bits give modulo wrap.
  function automatic logic [ACC_WIDTH-1:0] pe_mul(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b,
                                                  input logic                  sgn);
    logic signed [DATA_WIDTH:0] ae;
    logic signed [DATA_WIDTH:0] be;
    logic signed [XW-1:0]       ax;
    logic signed [XW-1:0]       bx;
    logic signed [XW-1:0]       p;
    ae = {sgn & a[DATA_WIDTH-1], a};
    be = {sgn & b[DATA_WIDTH-1], b};
    ax = XW'(ae);
    bx = XW'(be);
    p  = ax * bx;
    return p[ACC_WIDTH-1:0];
  endfunction

  // Skewed injection: at compute cycle t, row r receives A[r][t-r] and column c
  // receives B[t-c][c]; zero outside the N-cycle window.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      inj_a[r] = '0;
      inj_b[r] = '0;
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CW'(r + k)) begin
          inj_a[r] = a_buf_q[r*N + k];
          inj_b[r] = b_buf_q[k*N + r];
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      a_in[r][0] = inj_a[r];
      for (int c = 1; c < N; c++) a_in[r][c] = a_pipe_q[r][c-1];
    end
    for (int c = 0; c < N; c++) begin
      b_in[0][c] = inj_b[c];
      for (int r = 1; r < N; r++) b_in[r][c] = b_pipe_q[r-1][c];
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        prod[r][c] = pe_mul(a_in[r][c], b_in[r][c], sgn_q);
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    a_buf_d  = a_buf_q;
    b_buf_d  = b_buf_q;
    a_pipe_d = a_pipe_q;
    b_pipe_d = b_pipe_q;
    c_d      = c_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (load_valid && load_ready_q) begin
          for (int i = 0; i < NN; i++) begin
            if (cnt_q == CW'(i)) begin
              a_buf_d[i] = A_i;
              b_buf_d[i] = B_i;
            end
          end
          if (cnt_q == CW'(NN - 1)) begin
            state_d = S_LOADED;
            cnt_d   = '0;
          end else begin
            state_d = S_LOAD;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      S_LOADED: begin
        if (start) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
          sgn_d   = signed_mode;
          acc_d   = acc_mode;
          // Start the skew pipeline from a known all-zero state.
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
              a_pipe_d[r][c] = '0;
              b_pipe_d[r][c] = '0;
            end
        end
      end
      S_COMPUTE: begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            a_pipe_d[r][c] = a_in[r][c];
            b_pipe_d[r][c] = b_in[r][c];
            // Clearing on cycle 0 is folded into the first accumulate.
            if (cnt_q == '0 && !acc_q) c_d[r][c] = prod[r][c];
            else                       c_d[r][c] = c_q[r][c] + prod[r][c];
          end
        if (cnt_q == CW'(LAST_COMP)) begin
          state_d = S_OUTPUT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (cnt_q == CW'(NN - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Registered so load_ready stays low while reset is asserted.
    load_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sgn_q        <= 1'b0;
      acc_q        <= 1'b0;
      load_ready_q <= 1'b0;
      for (int i = 0; i < NN; i++) begin
        a_buf_q[i] <= '0;
        b_buf_q[i] <= '0;
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_pipe_q[r][c] <= '0;
          b_pipe_q[r][c] <= '0;
          c_q[r][c]      <= '0;
        end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sgn_q        <= sgn_d;
      acc_q        <= acc_d;
      load_ready_q <= load_ready_d;
      a_buf_q      <= a_buf_d;
      b_buf_q      <= b_buf_d;
      a_pipe_q     <= a_pipe_d;
      b_pipe_q     <= b_pipe_d;
      c_q          <= c_d;
    end
  end

  // Outputs
  always_comb begin
    result = '0;
    if (state_q == S_OUTPUT) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          if (cnt_q == CW'(r*N + c)) result = c_q[r][c];
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = (state_q == S_COMPUTE) || (state_q == S_OUTPUT);
  assign done       = (state_q == S_COMPUTE) && (cnt_q == CW'(LAST_COMP));
  assign out_valid  = (state_q == S_OUTPUT);
  assign out_last   = (state_q == S_OUTPUT) && (cnt_q == CW'(NN - 1));

endmodule

// File: tb/tb_systolic_mm_engine.sv
module tb_systolic_mm_engine;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [DW-1:0] A_i = '0;
  logic [DW-1:0] B_i = '0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic          acc_mode = 1'b0;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] result;
  logic          out_last;

  systolic_mm_engine #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready),
    .A_i(A_i), .B_i(B_i),
    .start(start), .signed_mode(signed_mode), .acc_mode(acc_mode),
    .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_last(out_last)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] ma [NN];
  logic [DW-1:0] mb [NN];
  logic [AW-1:0] c_model [NN];
  logic [AW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: computes C independently and pushes the readout order
  task automatic model_run(input bit sgn, input bit acc);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [AW-1:0] sum;
        sum = acc ? c_model[i*N+j] : '0;
        for (int k = 0; k < N; k++) begin
          longint av, bv;
          av = sgn ? longint'($signed(ma[i*N+k])) : longint'(ma[i*N+k]);
          bv = sgn ? longint'($signed(mb[k*N+j])) : longint'(mb[k*N+j]);
          sum += AW'(av * bv);
        end
        c_model[i*N+j] = sum;
      end
    for (int i = 0; i < NN; i++) exp_q.push_back(c_model[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NN; i++) c_model[i] = '0;
    exp_q.delete();
  endtask

  // driver: stream ma/mb with random idle gaps
  task automatic load_mats();
    for (int k = 0; k < NN; k++) begin
      int w;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      load_valid = 1'b1;
      A_i = ma[k];
      B_i = mb[k];
      w = 0;
      while (!load_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) check("load_timeout", 64'(w), 64'(0));
      @(negedge clk);
      load_valid = 1'b0;
    end
    check("load_ready_drop", 64'(load_ready), 64'(0));
    // extra pair offered in LOADED must be ignored
    load_valid = 1'b1;
    A_i = 8'h5A;
    B_i = 8'hA5;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // driver: start and measure done latency (counting the accepting edge)
  task automatic do_start(input bit sgn, input bit acc);
    int cyc;
    signed_mode = sgn;
    acc_mode = acc;
    start = 1'b1;
    model_run(sgn, acc);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 60) begin
      check("busy_compute", 64'(busy), 64'(1));
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'(3*N - 1));
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
    check("out_valid_up", 64'(out_valid), 64'(1));
  endtask

  // scoreboard: pop and compare on each readout transfer
  task automatic drain(input bit bp);
    int got, cyc;
    bit stalled;
    logic [AW-1:0] held;
    logic held_last;
    got = 0;
    cyc = 0;
    stalled = 0;
    held = '0;
    held_last = 1'b0;
    while (got < NN && cyc < 300) begin
      if (stalled && out_valid) begin
        check("stall_hold", 64'(result), 64'(held));
        check("stall_last", 64'(out_last), 64'(held_last));
      end
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (out_valid && out_ready) begin
        logic [AW-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("result", 64'(result), 64'(e));
        check("out_last", 64'(out_last), 64'(got == NN - 1));
        got++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = result;
        held_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_count", 64'(got), 64'(NN));
    out_ready = 1'b0;
    check("out_valid_end", 64'(out_valid), 64'(0));
    check("busy_end", 64'(busy), 64'(0));
  endtask

  initial begin
    model_clear();

    // 1. reset with load_valid high
    load_valid = 1'b1;
    A_i = 8'h77;
    B_i = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("rst_outs", 64'({load_ready, busy, done, out_valid, out_last, result}), 64'(0));
    end
    rst_n = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    check("load_ready_rise", 64'(load_ready), 64'(1));

    // 2. A = B = column index, unsigned, clear
    for (int i = 0; i < NN; i++) begin
      ma[i] = DW'(i % N);
      mb[i] = DW'(i % N);
    end
    load_mats();
    do_start(1'b0, 1'b0);
    drain(1'b0);

    // 3. same data, accumulate
    load_mats();
    do_start(1'b0, 1'b1);
    drain(1'b0);

    // 4/5. all-ones A against 2*identity, signed with backpressure, then unsigned
    for (int i = 0; i < NN; i++) begin
      ma[i] = 8'hFF;
      mb[i] = ((i / N) == (i % N)) ? 8'd2 : 8'd0;
    end
    load_mats();
    do_start(1'b1, 1'b0);
    drain(1'b1);
    load_mats();
    do_start(1'b0, 1'b0);
    drain(1'b0);

    // random operands, random sign mode, accumulate on top of previous C
    for (int i = 0; i < NN; i++) begin
      ma[i] = DW'($urandom_range(0, 255));
      mb[i] = DW'($urandom_range(0, 255));
    end
    load_mats();
    do_start(1'($urandom_range(0, 1)), 1'b1);
    drain(1'b1);

    // 6. reset in the middle of COMPUTE
    load_mats();
    signed_mode = 1'b0;
    acc_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_outs", 64'({busy, done, out_valid, load_ready}), 64'(0));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        start = (c == 3);
        @(negedge clk);
        if (done || out_valid || busy) seen++;
      end
      start = 1'b0;
      check("abort_quiet", 64'(seen), 64'(0));
    end
    // fresh run after abort; acc_mode = 1 exposes any C left behind
    for (int i = 0; i < NN; i++) begin
      ma[i] = DW'($urandom_range(0, 255));
      mb[i] = DW'($urandom_range(0, 255));
    end
    load_mats();
    do_start(1'b1, 1'b1);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised successor to the serial-load systolic matrix-matrix multiplier.
- Computes C = A x B (or C += A x B) for N x N matrices on an output-stationary N x N PE array with skewed operand injection.
- Adds valid/ready load and readout handshakes, runtime signed/unsigned mode, tile accumulation and a done/last protocol.
- Sits between the operand streaming front end and the result collector.

Parameters:
DATA_WIDTH, 8, operand element width
N, 4, matrix dimension; PE array is N x N; N >= 2
ACC_WIDTH, 2*DATA_WIDTH+$clog2(N)+2, accumulator/result width; must be >= 2*DATA_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  A_i/B_i element pair valid
load_ready  output  1  engine accepts element pair
A_i  input  DATA_WIDTH  A[r][c], row-major order
B_i  input  DATA_WIDTH  B[r][c], same index as A_i
start  input  1  begin compute; honoured only in LOADED
signed_mode  input  1  sampled at accepted start; 1 = two's-complement operands
acc_mode  input  1  sampled at accepted start; 1 = add to retained C, 0 = clear C first
busy  output  1  high in COMPUTE and OUTPUT
done  output  1  one-cycle pulse when COMPUTE finishes
out_valid  output  1  result valid
out_ready  input  1  collector accepts result
result  output  ACC_WIDTH  C[r][c], row-major order
out_last  output  1  high with C[N-1][N-1]

Behaviour:
- Reset (async, any state): FSM to IDLE; load/compute/output counters cleared; C and operand buffers cleared. All outputs 0 while rst_n low; load_ready rises in the first cycle after deassertion.
- States: IDLE, LOAD, LOADED, COMPUTE, OUTPUT.
- IDLE/LOAD:
  - load_ready = 1.
  - Each load_valid && load_ready edge stores one pair at index k = 0..N*N-1 and increments k; IDLE goes to LOAD on the first transfer.
  - The N*N-th transfer goes to LOADED; load_ready drops the following cycle.
- LOADED:
  - load_ready = 0.
  - start goes to COMPUTE and latches signed_mode and acc_mode.
  - start in any other state is ignored. load_valid outside IDLE/LOAD is ignored.
- COMPUTE:
  - Exactly 3*N-1 cycles. If acc_mode = 0, C is cleared on cycle 0.
  - Row r of A is injected skewed by r cycles; column c of B is skewed by c cycles; PEs pass A rightward and B downward, one register per hop; zero is injected outside the valid window.
  - On the last COMPUTE cycle, done = 1 and the FSM goes to OUTPUT.
- Arithmetic:
  - signed_mode = 1: operands sign-extended, signed product.
  - signed_mode = 0: zero-extended.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation or flag.
- OUTPUT:
  - out_valid = 1; result = C[idx] with row-major idx = 0..N*N-1.
  - idx advances only on out_valid && out_ready. result and out_last are held stable while out_valid && !out_ready.
  - The transfer with out_last goes to IDLE; out_valid is 0 the next cycle.
- C retention: C is retained after OUTPUT for the next acc_mode = 1 run. Operand buffers are overwritten by the next load.
- Reset mid-operation aborts immediately: no done pulse, no partial results.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with load_valid = 1 -> all outputs 0; load_ready = 1 on the first cycle after release; no element captured during reset.
2. N = 4, unsigned, acc_mode = 0; A[r][c] = B[r][c] = c; 16 load transfers; start -> done exactly 11 cycles after start; 16 results 0,6,12,18 repeated per row, out_last on the 16th.
3. Repeat scenario 2 with acc_mode = 1, same data -> results 0,12,24,36 per row.
4. A = all 0xFF, B = 2*identity:
   - signed_mode = 1 -> every result 0x3FFFE (-2 in 18 bits).
   - signed_mode = 0 -> every result 510.
5. Backpressure: out_ready pattern 1,0,0,1 repeating -> result stable during stalls; exactly 16 transfers in order, no drops or duplicates; busy falls after the last transfer.
6. Pulse rst_n low mid-COMPUTE, and pulse start in IDLE -> no done, busy = 0, out_valid never asserts; a fresh load plus start then produces correct results.
